sin_spi_rx: RTL



---
 rtl/sin_spi_rx.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/sin_spi_rx.sv
// sin_spi_rx: SPI mode-0 slave front end. Oversamples CS_b/SCLK/MOSI in the
// CLK domain, assembles WORD_W-bit frames, tags each with a channel index,
// and queues them in a 2-entry valid/ready buffer. MISO shifts a link-check
// word out during each frame.
// Build option: define SPI_ECHO_EN to echo the last accepted word on MISO
// (default: MISO always shifts IDLE_WORD).
//
// state  | meaning
// IDLE   | CS_b high, gap counter running
// SHIFT  | CS_b low, shifting MOSI in / MISO out
// DONE   | one cycle: push word or flag frame error
module sin_spi_rx #(
    parameter int          WORD_W    = 16,
    parameter int          NUM_CH    = 16,
    parameter int          CH_W      = 4,
    parameter int          SYNC_GAP  = 64,
    parameter logic [15:0] IDLE_WORD = 16'hA5C3
) (
    input  logic              CLK,
    input  logic              PB,
    input  logic              CS_b,
    input  logic              SCLK,
    input  logic              MOSI,
    output logic              MISO,
    output logic [WORD_W-1:0] samp_data,
    output logic [CH_W-1:0]   samp_ch,
    output logic              samp_valid,
    input  logic              samp_ready,
    output logic              frame_err,
    output logic              ovf,
    input  logic              err_clr
);

    localparam int              GAP_W    = $clog2(SYNC_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(SYNC_GAP);
    localparam logic [4:0]      WORD_CNT = 5'(WORD_W);
    localparam logic [CH_W-1:0] CH_LAST  = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

    // synchroniser / history flops and registered edge strobes
    logic cs_s1_q, cs_s2_q, cs_h_q;
    logic sclk_s1_q, sclk_s2_q, sclk_h_q;
    logic mosi_s1_q, mosi_s2_q, mosi_h_q;
    logic cs_fall_q, cs_rise_q, sclk_rise_q, sclk_fall_q;

    state_t              state_q;
    logic [4:0]          bit_cnt_q;
    logic [WORD_W-1:0]   shift_q;
    logic [WORD_W-1:0]   miso_sr_q;
    logic                miso_q;
    logic [CH_W-1:0]     ch_q;
    logic [GAP_W-1:0]    gap_q;
    logic                frame_err_q;
    logic [WORD_W-1:0]   load_word;

    logic [WORD_W-1:0]   mem_data_q [2];
    logic [CH_W-1:0]     mem_ch_q   [2];
    logic                wr_ptr_q, rd_ptr_q;
    logic [1:0]          count_q;
    logic                ovf_q;

    logic word_ok, push, pop, full, accept;

    assign word_ok = (bit_cnt_q == WORD_CNT);
    assign push    = (state_q == ST_DONE) && word_ok;
    assign pop     = (count_q != 2'd0) && samp_ready;
    assign full    = (count_q == 2'd2);
    assign accept  = push && (!full || pop);

    // Synchronise the SPI pins and register their edges. The CS_b chain
    // resets low so that releasing PB while CS_b is already low (aborted
    // frame) never looks like a fresh falling edge.
    always_ff @(posedge CLK or negedge PB) begin
        if (!PB) begin
            cs_s1_q     <= 1'b0;
            cs_s2_q     <= 1'b0;
            cs_h_q      <= 1'b0;
            sclk_s1_q   <= 1'b0;
            sclk_s2_q   <= 1'b0;
            sclk_h_q    <= 1'b0;
            mosi_s1_q   <= 1'b0;
            mosi_s2_q   <= 1'b0;
            mosi_h_q    <= 1'b0;
            cs_fall_q   <= 1'b0;
            cs_rise_q   <= 1'b0;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
        end else begin
            cs_s1_q     <= CS_b;
            cs_s2_q     <= cs_s1_q;
            cs_h_q      <= cs_s2_q;
            sclk_s1_q   <= SCLK;
            sclk_s2_q   <= sclk_s1_q;
            sclk_h_q    <= sclk_s2_q;
            mosi_s1_q   <= MOSI;
            mosi_s2_q   <= mosi_s1_q;
            mosi_h_q    <= mosi_s2_q;
            cs_fall_q   <= cs_h_q & ~cs_s2_q;
            cs_rise_q   <= ~cs_h_q & cs_s2_q;
            sclk_rise_q <= ~sclk_h_q & sclk_s2_q;
            sclk_fall_q <= sclk_h_q & ~sclk_s2_q;
        end
    end

`ifdef SPI_ECHO_EN
    logic [WORD_W-1:0] echo_q;

    // Remember the last word that made it into the buffer for read-back.
    always_ff @(posedge CLK or negedge PB) begin
        if (!PB)         echo_q <= IDLE_WORD;
        else if (accept) echo_q <= shift_q;
    end

    assign load_word = echo_q;
`else
    assign load_word = IDLE_WORD;
`endif

    // Frame FSM: bit counting, shift registers, channel index, scan gap.
    always_ff @(posedge CLK or negedge PB) begin
        if (!PB) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 5'd0;
            shift_q     <= '0;
            miso_sr_q   <= '0;
            miso_q      <= 1'b0;
            ch_q        <= '0;
            gap_q       <= GAP_MAX;
            frame_err_q <= 1'b0;
        end else begin
            if (err_clr) frame_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    miso_q <= 1'b0;
                    if (cs_fall_q) begin
                        state_q   <= ST_SHIFT;
                        bit_cnt_q <= 5'd0;
                        miso_sr_q <= {load_word[WORD_W-2:0], 1'b0};
                        miso_q    <= load_word[WORD_W-1];
                        gap_q     <= '0;
                        if (gap_q >= GAP_MAX) ch_q <= '0;
                    end else if (gap_q < GAP_MAX) begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (cs_rise_q) begin
                        state_q <= ST_DONE;
                        miso_q  <= 1'b0;
                    end else begin
                        if (sclk_rise_q) begin
                            shift_q <= {shift_q[WORD_W-2:0], mosi_h_q};
                            if (bit_cnt_q != 5'd31) bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                        if (sclk_fall_q) begin
                            miso_q    <= miso_sr_q[WORD_W-1];
                            miso_sr_q <= {miso_sr_q[WORD_W-2:0], 1'b0};
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    if (word_ok) begin
                        // advances even when the buffer drops the word
                        ch_q <= (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
                    end else begin
                        frame_err_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Two-entry sample buffer with overflow flag.
    always_ff @(posedge CLK or negedge PB) begin
        if (!PB) begin
            mem_data_q[0] <= '0;
            mem_data_q[1] <= '0;
            mem_ch_q[0]   <= '0;
            mem_ch_q[1]   <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
            ovf_q         <= 1'b0;
        end else begin
            if (accept) begin
                mem_data_q[wr_ptr_q] <= shift_q;
                mem_ch_q[wr_ptr_q]   <= ch_q;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            case ({accept, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
            if (err_clr) ovf_q <= 1'b0;
            if (push && !accept) ovf_q <= 1'b1;
        end
    end

    assign MISO       = miso_q;
    assign samp_data  = mem_data_q[rd_ptr_q];
    assign samp_ch    = mem_ch_q[rd_ptr_q];
    assign samp_valid = (count_q != 2'd0);
    assign frame_err  = frame_err_q;
    assign ovf        = ovf_q;

endmodule
